// File: rtl/add_rr_arbiter.sv
// rtl/add_rr_arbiter.sv - round-robin arbiter sharing one registered 16-bit adder
//
// Purpose: NREQ requesters each offer an operand pair over a valid/ready handshake.
//   One pair is granted in round-robin order and its sum is computed in a registered
//   add stage. The sum comes back over a valid/ready response channel, tagged with
//   the index of the requester that owns it.
//
// Optional feature macro: ADD_ARB_CARRY_EN. When it is defined, the rsp_carry output
//   is added. It is registered alongside rsp_sum.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active-low
//   req_valid  in   NREQ     bit i: requester i offers an operand pair
//   req_ready  out  NREQ     bit i: requester i is accepted this cycle (one-hot or zero)
//   req_a      in   NREQ*16  operand A, requester i at [16*i+15:16*i]
//   req_b      in   NREQ*16  operand B, same packing
//   rsp_valid  out  1        result available
//   rsp_ready  in   1        consumer takes the result
//   rsp_id     out  IDW      owner of the result
//   rsp_sum    out  16       (a+b) mod 2^16
//   busy       out  1        high whenever the FSM is not idle
//   rsp_carry  out  1        bit 16 of the sum (ADD_ARB_CARRY_EN only)
module add_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [15:0]        rsp_sum
`ifdef ADD_ARB_CARRY_EN
  ,
  output logic               rsp_carry
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [15:0]    op_a, op_b;
  logic [15:0]    sum_q;
`ifdef ADD_ARB_CARRY_EN
  logic           carry_q;
`endif

  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic [15:0]    sel_a, sel_b;
  logic           accept;

  // Search from rr_ptr upward, modulo NREQ. The loop runs from the farthest
  // offset down to offset 0, so the nearest valid requester is written last
  // and wins.
  always_comb begin
    logic [IDW:0] pos;
    pos       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
      if (req_valid[pos[IDW-1:0]]) begin
        gnt_idx   = pos[IDW-1:0];
        gnt_found = 1'b1;
      end
    end
  end

  // Operand mux and one-hot ready. Constant part-select bases keep this
  // decode free of variable-width indexing.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
        // Gated by rst so that ready stays low while reset is asserted.
        req_ready[i] = rst && (state == IDLE) && gnt_found;
      end
    end
  end

  assign accept = (state == IDLE) && gnt_found;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
`ifdef ADD_ARB_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        id_q   <= gnt_idx;
        rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      end
      if (state == CALC) begin
`ifdef ADD_ARB_CARRY_EN
        {carry_q, sum_q} <= {1'b0, op_a} + {1'b0, op_b};
`else
        sum_q <= op_a + op_b;
`endif
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
`ifdef ADD_ARB_CARRY_EN
  assign rsp_carry = carry_q;
`endif

endmodule
